button_debouncer: RTL
=====================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 320000 (10 ms at 32 MHz), number of consecutive stable cycles needed to accept a level change; legal range 2..2^24.
REQ-002 clk  input  1  sole clock; one clock.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 up_, down_, left_, right_  input  1 each  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-005 up_debounced, down_debounced, left_debounced, right_debounced  output  1 each  registered debounced level, active-high (1 = pressed); feeds the Konami acceptor.
REQ-006 press_pulse  output  4  one-cycle strobe per button on debounced press; bit order [0]=up, [1]=down, [2]=left, [3]=right.

Function
REQ-007 Each raw input SHALL pass through a two-flop synchronizer, then be inverted to an active-high sample.
REQ-008 Each channel SHALL hold a counter sized $clog2(DEBOUNCE_CYCLES) bits and a registered debounced state.
REQ-009 Sample equals debounced state -> counter cleared to 0 that cycle.
REQ-010 Sample differs and counter < DEBOUNCE_CYCLES-1 -> counter increments by 1.
REQ-011 Sample differs and counter == DEBOUNCE_CYCLES-1 -> debounced state takes the sample value and counter clears; counter never wraps.
REQ-012 A single-cycle glitch of opposite value SHALL restart the count from 0, i.e. acceptance needs DEBOUNCE_CYCLES consecutive differing samples.
REQ-013 Latency: a clean raw edge held stable SHALL appear on *_debounced exactly DEBOUNCE_CYCLES+2 clk cycles after the first synchronizer flop captures it.
REQ-014 press_pulse[i] SHALL be 1 for exactly the one cycle after debounced[i] goes 0->1; no pulse on release.
REQ-015 Channels SHALL be fully independent; simultaneous changes on several buttons SHALL each debounce and pulse in the same cycle without interaction.
REQ-016 Input held pressed indefinitely SHALL yield a steady 1 and only one pulse.

Reset
REQ-017 While reset=1 at a clk edge: synchronizer flops load 1 (released), counters load 0, all *_debounced load 0, press_pulse loads 4'b0000.
REQ-018 Reset asserted mid-count or while a button is held SHALL discard the partial count; no pulse is generated by reset assertion or release.
REQ-019 A button held through reset release SHALL be re-debounced from 0 and produce one press pulse after REQ-013 latency.

Configuration
REQ-020 Macro BUTTON_PRESS_PULSE_EN: defined -> press_pulse behaves per REQ-014; undefined -> edge-detect logic omitted and press_pulse tied to 4'b0000; port list unchanged either way.

Structure
REQ-021 Shared package konami_pkg SHALL hold button index constants (BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3), NUM_BUTTONS=4 and DEBOUNCE_CYCLES_DEFAULT=320000.
REQ-022 Sub-module debounce_channel (synchronizer, counter, state, edge detect) SHALL be instantiated four times; button_debouncer only maps ports.

Verification (DEBOUNCE_CYCLES=8, BUTTON_PRESS_PULSE_EN defined unless noted)
REQ-023 up_ 1->0 held 20 cycles -> up_debounced rises exactly 10 cycles after the edge; press_pulse=4'b0001 for one cycle; then up_ 0->1 -> up_debounced falls 10 cycles later, no pulse.
REQ-024 down_ low for 7 cycles then high -> down_debounced stays 0, no pulse; low 5, high 1, low 8 -> rises only after the final 8-cycle run.
REQ-025 left_ and right_ fall in the same cycle -> both *_debounced rise same cycle; press_pulse=4'b1100 for one cycle.
REQ-026 up_ low, reset pulsed after 5 cycles of count -> up_debounced 0 during reset; after release, rises 10 cycles later with one pulse.
REQ-027 Sequence up,up,down,down,left,right,left,right, each low 12 / high 12 cycles -> eight pulses in order on bits 0,0,1,1,2,3,2,3, no extra pulses.
REQ-028 BUTTON_PRESS_PULSE_EN undefined, repeat REQ-023 -> debounced timing identical, press_pulse constantly 4'b0000.

Source files
------------

// File: rtl/konami_pkg.sv
// Shared constants for the Konami-code input path: button indices and debounce defaults.
// Used by button_debouncer (optional macro BUTTON_PRESS_PULSE_EN) and its channels.
package konami_pkg;

   localparam int NUM_BUTTONS             = 4;
   localparam int BTN_UP                  = 0;
   localparam int BTN_DOWN                = 1;
   localparam int BTN_LEFT                = 2;
   localparam int BTN_RIGHT               = 3;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 320000;

   typedef logic [NUM_BUTTONS-1:0] btn_vec_t;

   // Counter width for a stable-cycle count; never narrower than one bit.
   function automatic int debounce_cnt_width(input int cycles);
      if (cycles > 2) begin
         return $clog2(cycles);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: two-flop synchronizer, stable-run counter, debounced state
// and registered output, plus a press strobe when BUTTON_PRESS_PULSE_EN is defined.
module debounce_channel
   import konami_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_raw_n,
   output logic o_debounced,
   output logic o_press_pulse
);

   localparam int             CW       = debounce_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   logic          r_sync1;
   logic          r_sync2;
   logic          w_sample;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_next;
   logic          r_state;
   logic          w_state_next;
   logic          r_debounced;

   // Synchronizer: both flops park at the released level (1) under reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_raw_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_sample = ~r_sync2;

   // Next count/state: any sample agreeing with the state restarts the run.
   always_comb begin
      w_count_next = r_count;
      w_state_next = r_state;
      if (w_sample == r_state) begin
         w_count_next = '0;
      end else if (r_count == CNT_LAST) begin
         w_count_next = '0;
         w_state_next = w_sample;
      end else begin
         w_count_next = r_count + CNT_ONE;
      end
   end

   // Counter, accepted state and the registered output copy of that state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count     <= '0;
         r_state     <= 1'b0;
         r_debounced <= 1'b0;
      end else begin
         r_count     <= w_count_next;
         r_state     <= w_state_next;
         r_debounced <= r_state;
      end
   end

   assign o_debounced = r_debounced;

`ifdef BUTTON_PRESS_PULSE_EN
   logic r_press_pulse;

   // Strobe lands in the same cycle the output first reads pressed.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_press_pulse <= 1'b0;
      end else begin
         r_press_pulse <= r_state & ~r_debounced;
      end
   end

   assign o_press_pulse = r_press_pulse;
`else
   assign o_press_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Four-button debouncer feeding the Konami acceptor; press strobes exist only
// when BUTTON_PRESS_PULSE_EN is defined (otherwise press_pulse is tied low).
module button_debouncer
   import konami_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   up_,
   input  logic                   down_,
   input  logic                   left_,
   input  logic                   right_,
   output logic                   up_debounced,
   output logic                   down_debounced,
   output logic                   left_debounced,
   output logic                   right_debounced,
   output logic [NUM_BUTTONS-1:0] press_pulse
);

   btn_vec_t w_raw_n;
   btn_vec_t w_debounced;

   assign w_raw_n[BTN_UP]    = up_;
   assign w_raw_n[BTN_DOWN]  = down_;
   assign w_raw_n[BTN_LEFT]  = left_;
   assign w_raw_n[BTN_RIGHT] = right_;

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
         .i_clk         (clk),
         .i_reset       (reset),
         .i_raw_n       (w_raw_n[g]),
         .o_debounced   (w_debounced[g]),
         .o_press_pulse (press_pulse[g])
      );
   end

   assign up_debounced    = w_debounced[BTN_UP];
   assign down_debounced  = w_debounced[BTN_DOWN];
   assign left_debounced  = w_debounced[BTN_LEFT];
   assign right_debounced = w_debounced[BTN_RIGHT];

endmodule
